// File: rtl/instr_fetch.sv
// instr_fetch: byte-wide instruction fetch unit with branch redirect and halt-on-opcode.
// Define FETCH_PREFETCH_EN to add a one-entry prefetch buffer for zero-bubble issue.
module instr_fetch #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
  parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [7:0]        imem_data,
  output logic [7:0]        ir_out,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              halt
);
  typedef enum logic [1:0] {FETCH, HOLD, HALT} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pend_addr_q, pend_addr_d;
  logic [7:0] ir_q, ir_d;
  logic ir_valid_q, ir_valid_d, req_q, req_d, pend_q, pend_d, ack;
`ifdef FETCH_PREFETCH_EN
  logic [7:0] buf_q, buf_d;
  logic buf_valid_q, buf_valid_d;
`endif
  assign ack = req_q & imem_ack;
  assign imem_req = req_q;
  assign imem_addr = pc_q;
  assign ir_out = ir_q;
  assign ir_valid = ir_valid_q;
  assign halt = state_q == HALT;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    ir_valid_d = ir_valid_q;
    req_d = req_q;
    pend_d = pend_q;
    pend_addr_d = pend_addr_q;
`ifdef FETCH_PREFETCH_EN
    buf_d = buf_q;
    buf_valid_d = buf_valid_q;
`endif
    if (branch_en) begin
      // an outstanding request must still complete; its data is dropped and pc redirected then
      state_d = FETCH;
      ir_valid_d = 1'b0;
      req_d = 1'b1;
      pend_d = req_q && !imem_ack;
      pend_addr_d = branch_addr;
      pc_d = pend_d ? pc_q : branch_addr;
`ifdef FETCH_PREFETCH_EN
      buf_valid_d = 1'b0;
`endif
    end else begin
      case (state_q)
        FETCH: begin
          if (!req_q) req_d = 1'b1;
          else if (ack && pend_q) begin
            pc_d = pend_addr_q;
            pend_d = 1'b0;
          end else if (ack) begin
            ir_d = imem_data;
            ir_valid_d = 1'b1;
            pc_d = pc_q + 1'b1;
            state_d = HOLD;
`ifdef FETCH_PREFETCH_EN
            req_d = imem_data != HALT_OPCODE;
`else
            req_d = 1'b0;
`endif
          end
        end
        HOLD: begin
`ifdef FETCH_PREFETCH_EN
          if (ack) pc_d = pc_q + 1'b1;
          if (ir_ready && buf_valid_q) begin
            ir_d = buf_q;
            buf_valid_d = 1'b0;
            req_d = buf_q != HALT_OPCODE;
          end else if (ir_ready && ack) begin
            ir_d = imem_data;
            req_d = imem_data != HALT_OPCODE;
          end else if (ack) begin
            buf_d = imem_data;
            buf_valid_d = 1'b1;
            req_d = 1'b0;
          end else if (ir_ready && req_q) begin
            ir_valid_d = 1'b0;
            state_d = FETCH;
          end else
`endif
          if (ir_ready) begin
            ir_valid_d = 1'b0;
            state_d = ir_q == HALT_OPCODE ? HALT : FETCH;
            req_d = ir_q != HALT_OPCODE;
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      ir_q <= 8'h00;
      ir_valid_q <= 1'b0;
      req_q <= 1'b0;
      pend_q <= 1'b0;
      pend_addr_q <= '0;
`ifdef FETCH_PREFETCH_EN
      buf_q <= 8'h00;
      buf_valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      ir_valid_q <= ir_valid_d;
      req_q <= req_d;
      pend_q <= pend_d;
      pend_addr_q <= pend_addr_d;
`ifdef FETCH_PREFETCH_EN
      buf_q <= buf_d;
      buf_valid_q <= buf_valid_d;
`endif
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch with a simple wait-state memory.
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imem_req, imem_ack, ir_valid, ir_ready, branch_en, halt;
  logic [7:0] imem_addr, imem_data, ir_out, branch_addr;
  logic [7:0] mem [256];
  logic mem_on, spur_ack;
  int mem_wait, cnt, checks, errors;

  instr_fetch dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .ir_out(ir_out), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .branch_en(branch_en), .branch_addr(branch_addr), .halt(halt)
  );

  always #5 clk = ~clk;

  // memory answers each request after mem_wait idle cycles; spur_ack fakes an unrequested ack
  initial begin
    imem_ack = 1'b0;
    imem_data = 8'h00;
    cnt = 0;
    forever begin
      @(negedge clk);
      #1;
      if (imem_req && mem_on) begin
        if (cnt >= mem_wait) begin
          imem_ack = 1'b1;
          imem_data = mem[imem_addr];
          cnt = 0;
        end else begin
          imem_ack = 1'b0;
          cnt++;
        end
      end else begin
        imem_ack = spur_ack && !imem_req;
        imem_data = spur_ack ? 8'hAA : 8'h00;
        cnt = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    branch_en = 1'b0;
    branch_addr = 8'h00;
    ir_ready = 1'b0;
    mem_on = 1'b0;
    spur_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    branch_en = 1'b0;
    ir_ready = 1'b0;
    mem_on = 1'b0;
    spur_ack = 1'b0;
    #1;
    checks++;
    if ({imem_req, ir_valid, halt} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: req/valid/halt=%b required 000", {imem_req, ir_valid, halt});
    end
    checks++;
    if (ir_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_ir: ir_out=%h required 00", ir_out);
    end
    checks++;
    if (imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_pc: imem_addr=%h required 00", imem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_first_req: req=%b addr=%h required 1/00", imem_req, imem_addr);
    end
  endtask

  task automatic test_branch_pending;
    int n;
    mem[8'h00] = 8'h01;
    mem[8'h05] = 8'h55;
    mem[8'h30] = 8'h33;
    mem[8'h40] = 8'h44;
    mem_wait = 2;
    do_reset;
    @(negedge clk);
    branch_addr = 8'h30;
    branch_en = 1'b1;
    @(negedge clk);
    branch_addr = 8'h05;
    @(negedge clk);
    branch_en = 1'b0;
    mem_on = 1'b1;
    n = 0;
    while (imem_addr === 8'h00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (imem_addr !== 8'h05 || imem_req !== 1'b1 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_overwrite: addr=%h req=%b valid=%b required 05/1/0", imem_addr, imem_req, ir_valid);
    end
    branch_addr = 8'h40;
    branch_en = 1'b1;
    @(negedge clk);
    branch_en = 1'b0;
    n = 0;
    while (imem_addr === 8'h05 && n < 20) begin
      checks++;
      if (ir_valid !== 1'b0) begin
        errors++;
        $display("FAIL discard_valid: ir_valid=%b ir_out=%h required 0", ir_valid, ir_out);
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (imem_addr !== 8'h40 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_target: addr=%h valid=%b required 40/0", imem_addr, ir_valid);
    end
    n = 0;
    while (!ir_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ir_valid !== 1'b1 || ir_out !== 8'h44) begin
      errors++;
      $display("FAIL redirect_data: valid=%b ir_out=%h required 1/44", ir_valid, ir_out);
    end
  endtask

  task automatic test_halt;
    int n;
    mem[8'h00] = 8'hFF;
    mem[8'h10] = 8'h11;
    mem_wait = 0;
    do_reset;
    mem_on = 1'b1;
    ir_ready = 1'b1;
    n = 0;
    while (!halt && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (halt !== 1'b1) begin
      errors++;
      $display("FAIL halt_enter: halt=%b required 1", halt);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({halt, imem_req, ir_valid} !== 3'b100) begin
        errors++;
        $display("FAIL halt_stay: cycle %0d halt/req/valid=%b required 100", i, {halt, imem_req, ir_valid});
      end
    end
    branch_addr = 8'h10;
    branch_en = 1'b1;
    @(negedge clk);
    branch_en = 1'b0;
    checks++;
    if (halt !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h10) begin
      errors++;
      $display("FAIL halt_exit: halt=%b req=%b addr=%h required 0/1/10", halt, imem_req, imem_addr);
    end
    ir_ready = 1'b0;
    n = 0;
    while (!ir_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ir_valid !== 1'b1 || ir_out !== 8'h11) begin
      errors++;
      $display("FAIL halt_resume: valid=%b ir_out=%h required 1/11", ir_valid, ir_out);
    end
  endtask

`ifdef FETCH_PREFETCH_EN
  task automatic test_prefetch;
    int n;
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h20 + i);
    mem_wait = 0;
    do_reset;
    mem_on = 1'b1;
    ir_ready = 1'b1;
    n = 0;
    while (!ir_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (ir_valid !== 1'b1 || ir_out !== 8'(8'h20 + k)) begin
        errors++;
        $display("FAIL prefetch_stream: step %0d valid=%b ir_out=%h required 1/%h", k, ir_valid, ir_out, 8'(8'h20 + k));
      end
      @(negedge clk);
    end
    ir_ready = 1'b0;
  endtask
`else
  task automatic test_seq;
    int n;
    mem[8'h00] = 8'h01;
    mem[8'h01] = 8'h02;
    mem_wait = 1;
    do_reset;
    mem_on = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL seq_req0: req=%b addr=%h required 1/00", imem_req, imem_addr);
    end
    n = 0;
    while (!ir_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ir_valid !== 1'b1 || ir_out !== 8'h01) begin
      errors++;
      $display("FAIL seq_ir0: valid=%b ir_out=%h required 1/01", ir_valid, ir_out);
    end
    ir_ready = 1'b1;
    @(negedge clk);
    ir_ready = 1'b0;
    checks++;
    if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h01) begin
      errors++;
      $display("FAIL seq_bubble: valid=%b req=%b addr=%h required 0/1/01", ir_valid, imem_req, imem_addr);
    end
    n = 0;
    while (!ir_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ir_valid !== 1'b1 || ir_out !== 8'h02) begin
      errors++;
      $display("FAIL seq_ir1: valid=%b ir_out=%h required 1/02", ir_valid, ir_out);
    end
  endtask

  task automatic test_hold;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({ir_valid, imem_req, ir_out, imem_addr} !== {1'b1, 1'b0, 8'h02, 8'h02}) begin
        errors++;
        $display("FAIL hold_stable: cycle %0d valid=%b req=%b ir_out=%h addr=%h required 1/0/02/02", i, ir_valid, imem_req, ir_out, imem_addr);
      end
    end
  endtask

  task automatic test_wrap;
    int n;
    mem[8'hFF] = 8'h33;
    branch_addr = 8'hFF;
    branch_en = 1'b1;
    @(negedge clk);
    branch_en = 1'b0;
    checks++;
    if (imem_addr !== 8'hFF || imem_req !== 1'b1 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_branch: addr=%h req=%b valid=%b required FF/1/0", imem_addr, imem_req, ir_valid);
    end
    n = 0;
    while (!ir_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ir_out !== 8'h33 || imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL wrap_pc: ir_out=%h addr=%h required 33/00", ir_out, imem_addr);
    end
    ir_ready = 1'b1;
    @(negedge clk);
    ir_ready = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL wrap_req: req=%b addr=%h required 1/00", imem_req, imem_addr);
    end
  endtask

  task automatic test_spurious;
    int n;
    mem[8'h00] = 8'h5A;
    mem_wait = 0;
    do_reset;
    mem_on = 1'b1;
    n = 0;
    while (!ir_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    spur_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({ir_valid, imem_req, ir_out, imem_addr} !== {1'b1, 1'b0, 8'h5A, 8'h01}) begin
        errors++;
        $display("FAIL spurious_ack: cycle %0d valid=%b req=%b ir_out=%h addr=%h required 1/0/5A/01", i, ir_valid, imem_req, ir_out, imem_addr);
      end
    end
    spur_ack = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    mem_wait = 1;
    mem_on = 1'b0;
    spur_ack = 1'b0;
    ir_ready = 1'b0;
    branch_en = 1'b0;
    branch_addr = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset;
`ifdef FETCH_PREFETCH_EN
    test_prefetch;
`else
    test_seq;
    test_hold;
    test_wrap;
    test_spurious;
`endif
    test_branch_pending;
    test_halt;
    test_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_W, default 8, width of program counter and instruction-memory address.
REQ-002 Parameter RESET_PC, default 8'h00, first fetch address after reset.
REQ-003 Parameter HALT_OPCODE, default 8'hFF, opcode that stops fetching once the control unit accepts it.
REQ-004 Clock and reset: one clock, clk; reset rst, asynchronous, active-high.
REQ-005 clk  input  1  sole clock; all state changes on posedge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 imem_req  output  1  registered read request to instruction memory.
REQ-008 imem_addr  output  ADDR_W  read address; stable while imem_req is high.
REQ-009 imem_ack  input  1  memory has imem_data valid this cycle.
REQ-010 imem_data  input  8  instruction byte.
REQ-011 ir_out  output  8  instruction register driven to the control unit.
REQ-012 ir_valid  output  1  ir_out holds an unconsumed instruction.
REQ-013 ir_ready  input  1  control unit accepts ir_out this cycle.
REQ-014 branch_en  input  1  one-cycle redirect strobe.
REQ-015 branch_addr  input  ADDR_W  redirect target.
REQ-016 halt  output  1  fetch stopped on HALT_OPCODE.

Function
REQ-017 States: FETCH (request outstanding), HOLD (IR valid, waiting for consumer), HALT.
REQ-018 In FETCH the block SHALL drive imem_req=1 and imem_addr=pc until imem_ack is sampled high.
REQ-019 On the imem_ack edge: ir_out<=imem_data, ir_valid<=1, pc<=pc+1, imem_req<=0, state<=HOLD; latency ack edge to ir_valid high is 0 cycles after that edge.
REQ-020 pc increment SHALL wrap modulo 2^ADDR_W (8'hFF -> 8'h00), no flag.
REQ-021 In HOLD, ir_out and ir_valid SHALL stay stable until an edge with ir_valid&ir_ready; on that edge ir_valid<=0 and state<=FETCH (imem_req high next cycle), or state<=HALT if ir_out==HALT_OPCODE.
REQ-022 HALT: halt=1, imem_req=0, ir_valid=0; exit only by rst or branch_en.
REQ-023 branch_en in HOLD or HALT: pc<=branch_addr, ir_valid<=0, halt<=0, state<=FETCH; branch wins over a same-edge ir_ready (instruction not counted as consumed).
REQ-024 branch_en in FETCH while the request is outstanding: target latched in a pending-redirect register; the returning imem_data SHALL be discarded (ir_valid stays 0), then a new request issues to the target next cycle; branch on the ack edge itself is treated identically.
REQ-025 A second branch_en before the discarded ack SHALL overwrite the pending target.
REQ-026 imem_ack while imem_req=0 SHALL be ignored.

Reset
REQ-027 rst SHALL asynchronously force pc=RESET_PC, ir_out=8'h00, ir_valid=0, imem_req=0, halt=0, pending redirect cleared, prefetch buffer empty.
REQ-028 First posedge after rst deasserts SHALL raise imem_req with imem_addr=RESET_PC; rst mid-transaction abandons it and a late ack is ignored per REQ-026.

Configuration
REQ-029 Macro FETCH_PREFETCH_EN: when defined, a one-entry prefetch buffer SHALL fetch pc while in HOLD, so an ir_ready handshake with the buffer full reloads ir_out from the buffer on the same edge, keeping ir_valid high (zero-bubble back-to-back issue).
REQ-030 With FETCH_PREFETCH_EN, no prefetch SHALL start while ir_out==HALT_OPCODE, and branch_en SHALL flush the buffer (in-flight data discarded per REQ-024).
REQ-031 Without FETCH_PREFETCH_EN, no buffer exists; at least one bubble cycle (ir_valid=0) separates consecutive instructions.

Verification
REQ-032 Reset release, memory acks every request after 1 wait cycle with 8'h01,8'h02 at 0,1 -> imem_addr 0 then 1, ir_out 8'h01 then 8'h02, ir_valid drops between them (macro off).
REQ-033 ir_ready held low 5 cycles in HOLD -> ir_out stable, imem_req=0 (macro off), no pc change.
REQ-034 pc=8'hFF fetch -> next imem_addr=8'h00.
REQ-035 branch_en with branch_addr=8'h40 while request to 8'h05 outstanding -> ack data discarded, next imem_addr=8'h40, ir_valid never high for 8'h05 data.
REQ-036 Fetch 8'hFF and handshake it -> halt=1, imem_req stays 0 for 10 cycles; branch_en to 8'h10 -> halt=0, imem_addr=8'h10.
REQ-037 Macro on, zero-wait memory, ir_ready tied high -> ir_valid continuously high after first instruction, one instruction accepted per cycle.
